mc_controller: RTL
==================

# mc_controller

Multicycle control FSM for the MIPS core. It sequences the shared ALU, memory port, PC and register-file writes over several cycles per instruction, and waits on a memory ready handshake. It sits between the instruction register / ALU flags and the datapath muxes and write enables. It produces the 4-bit ALU control code directly, using the team's ALU encoding.

## Interface
- No parameters.
- `clk  in  1` — rising-edge clock.
- `rst_n  in  1` — asynchronous, active-low reset.
- `instr  in  32` — instruction register contents; stable from DECODE until return to FETCH.
- `zero  in  1` — ALU zero flag, combinational from the current ALU op.
- `mem_ready  in  1` — memory completes the current access this cycle; sampled only while `mem_req`=1.
- `mem_req  out  1` — memory access request.
- `mem_we  out  1` — write qualifier for `mem_req`.
- `iord  out  1` — memory address select: 0=PC, 1=ALUOut.
- `irwrite  out  1` — IR load enable.
- `pcwrite  out  1` — PC load enable (already branch-resolved).
- `regwrite  out  1` — register-file write enable.
- `regdst  out  1` — 1=rd, 0=rt.
- `memtoreg  out  1` — 1=MDR, 0=ALUOut.
- `alusrca  out  1` — 0=PC, 1=rs.
- `alusrcb  out  2` — 00=rt, 01=const 4, 10=imm ext, 11=imm ext<<2.
- `ext_zero  out  1` — zero-extend the immediate (andi/ori/xori).
- `pcsrc  out  2` — 00=ALU result, 01=ALUOut, 10=jump target.
- `alucontrol  out  4` — ALU operation code.
- `illegal  out  1` — core trapped on an unsupported opcode/funct.

## Operation
- ALU codes: and 0000, or 0001, add 0010, xor 0011, sub 0110, slt 0111, nor 1000, mult 1001, sll 1010, srl 1011.
- State register is 4 bits. Outputs are Moore from state, except `pcwrite`/`irwrite` in FETCH and `pcwrite` in BRANCH. Unlisted outputs are 0; unlisted `alucontrol` = add.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, add.
  - Holds while `mem_ready`=0.
  - On `mem_ready`: `irwrite`=`pcwrite`=1, `pcsrc`=00, go to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11, add (branch target into ALUOut). Next state by `instr[31:26]`:
  - 100011/101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100/000101 → BRANCH
  - 001000/001010/001100/001101/001110 → IMMEX
  - 000010 → JUMP
  - anything else → TRAP
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req`=1, `iord`=1; waits for `mem_ready`, then MEMWB.
- MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1; then FETCH.
- MEMWR: `mem_req`=`mem_we`=`iord`=1; waits for `mem_ready`, then FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct:
  - 100100 and, 100101 or, 100000 add, 100110 xor, 100010 sub, 101010 slt, 100111 nor, 011000 mult, 000000 sll, 000010 srl.
  - Other funct → TRAP (no writeback). Otherwise RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1, `memtoreg`=0; then FETCH.
- BRANCH:
  - `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01.
  - `pcwrite` = (beq & `zero`) | (bne & ~`zero`).
  - Then FETCH.
- IMMEX:
  - `alusrca`=1, `alusrcb`=10.
  - Op: addi add, slti slt, andi and, ori or, xori xor.
  - `ext_zero`=1 for andi/ori/xori.
  - Then IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0; then FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1; then FETCH.
- TRAP: `illegal`=1, all enables and requests 0. Terminal until reset.

## Timing
- Reset:
  - `rst_n`=0 forces state=FETCH asynchronously.
  - While low, `mem_req`, `mem_we`, `irwrite`, `pcwrite`, `regwrite` and `illegal` are 0. Mux selects take FETCH values; `alucontrol`=0010.
  - First request is issued in the first cycle with `rst_n`=1.
- Latency with `mem_ready` held at 1:
  - R-type / imm / sw: 4 cycles.
  - lw: 5 cycles.
  - branch / jump: 3 cycles.
  - Each wait cycle adds 1.
- Handshake: `mem_req` stays high and address/`mem_we` stay stable until the cycle with `mem_ready`=1. `mem_ready` outside a request state is ignored.
- At most one of `irwrite`/`regwrite`/`mem_we` is active per cycle. `pcwrite` only in FETCH, BRANCH, JUMP.
- Reset mid-access or mid-writeback aborts immediately; no partial write completes after `rst_n` falls.

## Structure
- Shared package/include `mips_ctrl_pkg`: state encodings, opcode constants, funct constants, ALU code constants. Reused by the datapath and the bench.
- One natural sub-module, `mc_alu_sel`: combinational state+opcode+funct → `alucontrol`, `ext_zero` and a funct-illegal flag.
- The FSM next-state and output logic stay in `mc_controller`.

## Test plan
- **Reset then add:** `rst_n` pulse, `mem_ready`=1, instr 0x012A4020 (add) → states FETCH, DECODE, RTYPEEX (`alucontrol`=0010), RTYPEWB (`regwrite`=1, `regdst`=1), then FETCH.
- **lw with stall:** instr 0x8D090004, `mem_ready` low 2 cycles in MEMRD → `mem_req`/`iord` held 3 cycles, MEMWB `memtoreg`=1; total 7 cycles.
- **beq/bne:** 0x11090003 with `zero`=1 → `pcwrite`=1, `pcsrc`=01 in BRANCH. Same with `zero`=0 → `pcwrite`=0. bne 0x15090003 gives the inverse.
- **ori and sw:** 0x3528FFFF → IMMEX `alucontrol`=0001, `ext_zero`=1. 0xAD090008 → MEMWR `mem_we`=1, no `regwrite` in any cycle.
- **Illegal:** opcode 111111, or R-type funct 001000 → TRAP, `illegal`=1 held, no further `mem_req`. Only `rst_n` recovers.
- **Async reset mid-MEMWR:** `rst_n` falls with `mem_ready`=0 → `mem_we`/`mem_req` drop the same instant, state=FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multicycle MIPS core: FSM states, opcodes,
// funct fields and ALU operation codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BRANCH  = 4'd8,
      S_IMMEX   = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11,
      S_TRAP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1000;
   localparam logic [3:0] ALU_MULT = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_sel.sv
// ALU operation select: maps controller state, opcode and funct to the ALU
// code, the immediate zero-extend flag and an unsupported-funct flag.
module mc_alu_sel
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [3:0] o_alucontrol,
   output logic       o_ext_zero,
   output logic       o_funct_illegal
);

   state_t     w_state;
   logic [3:0] w_funct_alu;

   assign w_state = state_t'(i_state);

   always_comb begin
      w_funct_alu     = ALU_ADD;
      o_funct_illegal = 1'b0;
      case (i_funct)
         F_AND:   w_funct_alu = ALU_AND;
         F_OR:    w_funct_alu = ALU_OR;
         F_ADD:   w_funct_alu = ALU_ADD;
         F_XOR:   w_funct_alu = ALU_XOR;
         F_SUB:   w_funct_alu = ALU_SUB;
         F_SLT:   w_funct_alu = ALU_SLT;
         F_NOR:   w_funct_alu = ALU_NOR;
         F_MULT:  w_funct_alu = ALU_MULT;
         F_SLL:   w_funct_alu = ALU_SLL;
         F_SRL:   w_funct_alu = ALU_SRL;
         default: o_funct_illegal = 1'b1;
      endcase
   end

   always_comb begin
      o_alucontrol = ALU_ADD;
      o_ext_zero   = 1'b0;
      case (w_state)
         S_RTYPEEX: o_alucontrol = w_funct_alu;
         S_BRANCH:  o_alucontrol = ALU_SUB;
         S_IMMEX: begin
            case (i_opcode)
               OP_SLTI: o_alucontrol = ALU_SLT;
               OP_ANDI: begin o_alucontrol = ALU_AND; o_ext_zero = 1'b1; end
               OP_ORI:  begin o_alucontrol = ALU_OR;  o_ext_zero = 1'b1; end
               OP_XORI: begin o_alucontrol = ALU_XOR; o_ext_zero = 1'b1; end
               default: o_alucontrol = ALU_ADD;
            endcase
         end
         default: o_alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback, stalling on the memory ready handshake.
module mc_controller
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        irwrite,
   output logic        pcwrite,
   output logic        regwrite,
   output logic        regdst,
   output logic        memtoreg,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic        ext_zero,
   output logic [1:0]  pcsrc,
   output logic [3:0]  alucontrol,
   output logic        illegal
);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] w_op;
   logic       w_funct_illegal;
   logic       w_mem_req, w_mem_we, w_irwrite, w_pcwrite, w_regwrite, w_illegal;
   logic       w_unused_instr;

   assign w_op           = instr[31:26];
   assign w_unused_instr = &{1'b0, instr[25:6]};

   mc_alu_sel u_alu_sel (
      .i_state         (r_state),
      .i_opcode        (w_op),
      .i_funct         (instr[5:0]),
      .o_alucontrol    (alucontrol),
      .o_ext_zero      (ext_zero),
      .o_funct_illegal (w_funct_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_irwrite  = 1'b0;
      w_pcwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_illegal  = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_RT;
      pcsrc      = PCSRC_ALU;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            alusrcb   = SRCB_FOUR;
            if (mem_ready) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = SRCB_IMMSH2;
            case (w_op)
               OP_LW, OP_SW:   w_next = S_MEMADR;
               OP_RTYPE:       w_next = S_RTYPEEX;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_IMMEX;
               OP_J:           w_next = S_JUMP;
               default:        w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            w_next  = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            iord      = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_regwrite = 1'b1;
            memtoreg   = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            iord      = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            w_next  = w_funct_illegal ? S_TRAP : S_RTYPEWB;
         end
         S_RTYPEWB: begin
            w_regwrite = 1'b1;
            regdst     = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            alusrca   = 1'b1;
            pcsrc     = PCSRC_ALUOUT;
            w_pcwrite = ((w_op == OP_BEQ) & zero) | ((w_op == OP_BNE) & ~zero);
            w_next    = S_FETCH;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            w_next  = S_IMMWB;
         end
         S_IMMWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_JUMP: begin
            pcsrc     = PCSRC_JUMP;
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
         end
         S_TRAP:  w_illegal = 1'b1;
         default: w_next = S_FETCH;
      endcase
   end

   // Reset parks the state in FETCH, so the request/enable outputs are gated
   // directly by rst_n to keep them low for the whole reset interval.
   assign mem_req  = rst_n & w_mem_req;
   assign mem_we   = rst_n & w_mem_we;
   assign irwrite  = rst_n & w_irwrite;
   assign pcwrite  = rst_n & w_pcwrite;
   assign regwrite = rst_n & w_regwrite;
   assign illegal  = rst_n & w_illegal;

endmodule
